// File: rtl/trace_recorder_pkg.sv
// ============================================================================
// Module      : trace_recorder_pkg
// Description : Shared grid geometry, state encodings and box index helpers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_recorder_pkg;

  localparam int GRID_N    = 4;
  localparam int NUM_BOXES = GRID_N * GRID_N;
  localparam int ORDER_W   = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_DRAWING = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  typedef logic [3:0] box_idx_t;

  // Box k lives at bit [15-k] of the bitmap and nibble [63-4k -: 4] of the order word.
  function automatic box_idx_t box_bit(input box_idx_t k);
    return 4'd15 - k;
  endfunction

  function automatic logic [5:0] nibble_lsb(input box_idx_t k);
    return 6'd60 - {k, 2'b00};
  endfunction

  function automatic logic [ORDER_W-1:0] order_nibble(
    input logic [NUM_BOXES*ORDER_W-1:0] order,
    input box_idx_t                     k
  );
    return order[nibble_lsb(k) +: ORDER_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_recorder_box_locator.sv
// ============================================================================
// Module      : trace_box_locator
// Description : Combinational pen cursor -> {in_grid, box_k} mapping
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_box_locator
  import trace_recorder_pkg::*;
#(
  parameter int BOX_PX = 25
) (
  input  logic [8:0] cursor_row,
  input  logic [9:0] cursor_col,
  input  logic [7:0] initial_row,
  input  logic [8:0] initial_col,
  output logic       in_grid,
  output box_idx_t   box_k
);

  localparam logic signed [10:0] c_b1 = 11'(BOX_PX);
  localparam logic signed [10:0] c_b2 = 11'(2 * BOX_PX);
  localparam logic signed [10:0] c_b3 = 11'(3 * BOX_PX);
  localparam logic signed [10:0] c_b4 = 11'(GRID_N * BOX_PX);

  logic signed [10:0] w_dr;
  logic signed [10:0] w_dc;

  // Signed offsets so a cursor above/left of the grid goes negative instead of wrapping.
  assign w_dr = $signed({2'b00, cursor_row}) - $signed({3'b000, initial_row});
  assign w_dc = $signed({1'b0, cursor_col}) - $signed({2'b00, initial_col});

  function automatic logic [1:0] band(input logic signed [10:0] d);
    if (d < c_b1)      return 2'd0;
    else if (d < c_b2) return 2'd1;
    else if (d < c_b3) return 2'd2;
    else               return 2'd3;
  endfunction

  assign in_grid = (w_dr >= 11'sd0) && (w_dr < c_b4) &&
                   (w_dc >= 11'sd0) && (w_dc < c_b4);
  assign box_k   = {band(w_dr), band(w_dc)};

endmodule

`default_nettype wire

// File: rtl/trace_recorder.sv
// ============================================================================
// Module      : trace_recorder
// Description : Two-stage pen-trace recorder for the 4x4 spell grid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_recorder
  import trace_recorder_pkg::*;
#(
  parameter int BOX_PX       = 25,
  parameter bit STRICT_ORDER = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trace_screen_on,
  input  logic                         pen_down,
  input  logic [8:0]                   cursor_row,
  input  logic [9:0]                   cursor_col,
  input  logic [7:0]                   initial_row,
  input  logic [8:0]                   initial_col,
  input  logic [NUM_BOXES*ORDER_W-1:0] trace_order,
  input  logic [5:0]                   trace_boxes,
  output logic [NUM_BOXES-1:0]         p1_traced,
  output logic [4:0]                   trace_step,
  output logic [3:0]                   last_box,
  output logic                         trace_done,
  output logic                         trace_error
);

  logic     w_loc_in_grid;
  box_idx_t w_loc_box;

  trace_box_locator #(.BOX_PX(BOX_PX)) u_locator (
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .initial_row (initial_row),
    .initial_col (initial_col),
    .in_grid     (w_loc_in_grid),
    .box_k       (w_loc_box)
  );

  logic                         s1_pen_q, s1_pen_d;
  logic                         s1_in_grid_q, s1_in_grid_d;
  box_idx_t                     s1_box_q, s1_box_d;
  logic                         pen_prev_q, pen_prev_d;
  logic [NUM_BOXES*ORDER_W-1:0] order_prev_q, order_prev_d;
  logic [5:0]                   boxes_prev_q, boxes_prev_d;
  logic [2:0]                   state_q, state_d;
  logic [NUM_BOXES-1:0]         traced_q, traced_d;
  logic [4:0]                   step_q, step_d;
  box_idx_t                     last_box_q, last_box_d;
  logic                         box_valid_q, box_valid_d;

  logic               w_entry;
  logic               w_pen_lift;
  logic               w_trace_changed;
  logic [5:0]         w_eff_boxes;
  logic [ORDER_W-1:0] w_nib;
  logic [4:0]         w_step_inc;
  logic               w_in_order;
  box_idx_t           w_bit;

  assign w_entry         = s1_pen_q && s1_in_grid_q && ((s1_box_q != last_box_q) || !box_valid_q);
  assign w_pen_lift      = pen_prev_q && !s1_pen_q;
  assign w_trace_changed = (trace_order != order_prev_q) || (trace_boxes != boxes_prev_q);
  assign w_eff_boxes     = (trace_boxes == 6'd0) ? 6'd1 : trace_boxes;
  assign w_nib           = order_nibble(trace_order, s1_box_q);
  assign w_step_inc      = step_q + 5'd1;
  assign w_bit           = box_bit(s1_box_q);
  // Nibble 0 can never equal step+1, so boxes outside the trace never match.
  assign w_in_order      = ({1'b0, w_nib} == w_step_inc) && ({2'b00, w_nib} <= w_eff_boxes);

  always_comb begin
    s1_pen_d     = pen_down;
    s1_in_grid_d = w_loc_in_grid;
    s1_box_d     = w_loc_box;
    pen_prev_d   = s1_pen_q;
    order_prev_d = trace_order;
    boxes_prev_d = trace_boxes;
    state_d      = state_q;
    traced_d     = traced_q;
    step_d       = step_q;
    last_box_d   = last_box_q;
    box_valid_d  = box_valid_q;

    if (!trace_screen_on) begin
      state_d     = ST_IDLE;
      traced_d    = '0;
      step_d      = '0;
      box_valid_d = 1'b0;
    end else if (w_trace_changed) begin
      state_d     = ST_ARMED;
      traced_d    = '0;
      step_d      = '0;
      box_valid_d = 1'b0;
    end else begin
      if (w_entry) begin
        last_box_d  = s1_box_q;
        box_valid_d = 1'b1;
      end else if (!s1_in_grid_q || w_pen_lift) begin
        box_valid_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED, ST_DRAWING: begin
          if (w_entry) begin
            state_d = ST_DRAWING;
            if (w_in_order) begin
              traced_d[w_bit] = 1'b1;
              step_d          = w_step_inc;
              if ({1'b0, w_step_inc} == w_eff_boxes) state_d = ST_DONE;
            end else if (!traced_q[w_bit]) begin
              if (STRICT_ORDER) state_d = ST_ERROR;
              else              traced_d[w_bit] = 1'b1;
            end
          end else if ((state_q == ST_DRAWING) && w_pen_lift &&
                       ({1'b0, step_q} < w_eff_boxes)) begin
            state_d  = ST_ARMED;
            traced_d = '0;
            step_d   = '0;
          end
        end
        ST_DONE: state_d = ST_DONE;
        ST_ERROR: begin
          if (w_pen_lift) begin
            state_d  = ST_ARMED;
            traced_d = '0;
            step_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_pen_q     <= 1'b0;
      s1_in_grid_q <= 1'b0;
      s1_box_q     <= '0;
      pen_prev_q   <= 1'b0;
      order_prev_q <= '0;
      boxes_prev_q <= '0;
      state_q      <= ST_IDLE;
      traced_q     <= '0;
      step_q       <= '0;
      last_box_q   <= '0;
      box_valid_q  <= 1'b0;
    end else begin
      s1_pen_q     <= s1_pen_d;
      s1_in_grid_q <= s1_in_grid_d;
      s1_box_q     <= s1_box_d;
      pen_prev_q   <= pen_prev_d;
      order_prev_q <= order_prev_d;
      boxes_prev_q <= boxes_prev_d;
      state_q      <= state_d;
      traced_q     <= traced_d;
      step_q       <= step_d;
      last_box_q   <= last_box_d;
      box_valid_q  <= box_valid_d;
    end
  end

  assign p1_traced   = traced_q;
  assign trace_step  = step_q;
  assign last_box    = last_box_q;
  assign trace_done  = (state_q == ST_DONE);
  assign trace_error = (state_q == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_trace_recorder.sv
// ============================================================================
// Module      : tb_trace_recorder
// Description : Directed + randomized self-checking bench for trace_recorder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_screen_on;
  logic        pen_down;
  logic [8:0]  cursor_row;
  logic [9:0]  cursor_col;
  logic [7:0]  initial_row;
  logic [8:0]  initial_col;
  logic [63:0] trace_order;
  logic [5:0]  trace_boxes;
  logic [15:0] p1_traced;
  logic [4:0]  trace_step;
  logic [3:0]  last_box;
  logic        trace_done;
  logic        trace_error;

  always #5 clk = ~clk;

  trace_recorder #(.BOX_PX(25), .STRICT_ORDER(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .trace_screen_on (trace_screen_on),
    .pen_down        (pen_down),
    .cursor_row      (cursor_row),
    .cursor_col      (cursor_col),
    .initial_row     (initial_row),
    .initial_col     (initial_col),
    .trace_order     (trace_order),
    .trace_boxes     (trace_boxes),
    .p1_traced       (p1_traced),
    .trace_step      (trace_step),
    .last_box        (last_box),
    .trace_done      (trace_done),
    .trace_error     (trace_error)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pipeline copy of each pen sample plus the recorder's visible state.
  typedef enum int {M_IDLE, M_ARMED, M_DRAW, M_DONE, M_ERR} mmode_t;
  mmode_t      m_mode = M_IDLE;
  bit          m_hit[16];
  int          m_step = 0, m_last = 0;
  bit          m_valid = 0;
  bit          m_s1_pen = 0, m_s1_in = 0, m_pen_prev = 0;
  int          m_s1_box = 0;
  logic [63:0] m_prev_order = '0;
  int          m_prev_boxes = 0;

  int tr_box[16];
  int tr_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_bitmap();
    logic [15:0] v = '0;
    for (int k = 0; k < 16; k++) v[15-k] = m_hit[k];
    return v;
  endfunction

  function automatic int nib_of(input logic [63:0] ord, input int k);
    return int'((ord >> (60 - 4*k)) & 64'hF);
  endfunction

  task automatic wipe_bitmap();
    for (int k = 0; k < 16; k++) m_hit[k] = 1'b0;
    m_step = 0;
  endtask

  task automatic tick();
    bit          p, inn, scr, rs, chg, lift, entry;
    int          r, c, bx, eff, n;
    logic [63:0] ord;
    p   = pen_down;
    r   = int'(cursor_row) - int'(initial_row);
    c   = int'(cursor_col) - int'(initial_col);
    inn = (r >= 0) && (r < 100) && (c >= 0) && (c < 100);
    bx  = inn ? (r / 25) * 4 + (c / 25) : 0;
    scr = trace_screen_on;
    rs  = reset;
    ord = trace_order;
    chg = (ord != m_prev_order) || (int'(trace_boxes) != m_prev_boxes);
    eff = (trace_boxes == 0) ? 1 : int'(trace_boxes);
    @(posedge clk);
    if (rs) begin
      m_mode = M_IDLE; wipe_bitmap(); m_last = 0; m_valid = 0;
      m_s1_pen = 0; m_s1_in = 0; m_s1_box = 0; m_pen_prev = 0;
      m_prev_order = '0; m_prev_boxes = 0;
    end else begin
      lift  = m_pen_prev && !m_s1_pen;
      entry = m_s1_pen && m_s1_in && (m_s1_box != m_last || !m_valid);
      if (!scr) begin
        m_mode = M_IDLE; wipe_bitmap(); m_valid = 0;
      end else if (chg) begin
        m_mode = M_ARMED; wipe_bitmap(); m_valid = 0;
      end else begin
        if (entry) begin m_last = m_s1_box; m_valid = 1; end
        else if (!m_s1_in || lift) m_valid = 0;
        case (m_mode)
          M_IDLE: m_mode = M_ARMED;
          M_ARMED, M_DRAW: begin
            if (entry) begin
              m_mode = M_DRAW;
              n = nib_of(ord, m_s1_box);
              if (n == m_step + 1 && n <= eff) begin
                m_hit[m_s1_box] = 1; m_step++;
                if (m_step == eff) m_mode = M_DONE;
              end else if (!m_hit[m_s1_box]) begin
                m_mode = M_ERR;
              end
            end else if (m_mode == M_DRAW && lift) begin
              m_mode = M_ARMED; wipe_bitmap();
            end
          end
          M_ERR: if (lift) begin m_mode = M_ARMED; wipe_bitmap(); end
          default: ;
        endcase
      end
      m_pen_prev = m_s1_pen;
      m_s1_pen = p; m_s1_in = inn; m_s1_box = bx;
      m_prev_order = ord; m_prev_boxes = int'(trace_boxes);
    end
    #1;
    chk("model_traced", 32'(p1_traced), 32'(model_bitmap()));
    chk("model_step",   32'(trace_step), 32'(m_step));
    chk("model_last",   32'(last_box),   32'(m_last));
    chk("model_done",   32'(trace_done), 32'(m_mode == M_DONE));
    chk("model_error",  32'(trace_error), 32'(m_mode == M_ERR));
  endtask

  task automatic samp(input bit p, input int r, input int c, input int n);
    pen_down   = p;
    cursor_row = 9'(r);
    cursor_col = 10'(c);
    repeat (n) tick();
  endtask

  task automatic load_order(input int n, input int nb);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[63 - 4*tr_box[i] -: 4] = 4'(i + 1);
    tr_n        = n;
    trace_order = v;
    trace_boxes = 6'(nb);
  endtask

  task automatic new_random_trace();
    int arr[16];
    int j, t, n;
    for (int i = 0; i < 16; i++) arr[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i); t = arr[i]; arr[i] = arr[j]; arr[j] = t;
    end
    n = $urandom_range(1, 6);
    for (int i = 0; i < 16; i++) tr_box[i] = arr[i];
    load_order(n, n - (($urandom_range(0, 3) == 0) ? 1 : 0));
    initial_row = 8'($urandom_range(0, 255));
    initial_col = 9'($urandom_range(0, 511));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_traced"}, 32'(p1_traced), 32'h0);
    chk({tag, "_step"},   32'(trace_step), 32'h0);
    chk({tag, "_last"},   32'(last_box), 32'h0);
    chk({tag, "_done"},   32'(trace_done), 32'h0);
    chk({tag, "_error"},  32'(trace_error), 32'h0);
  endtask

  initial begin
    int bx, sel;
    reset = 1'b1; trace_screen_on = 1'b0; pen_down = 1'b0;
    cursor_row = '0; cursor_col = '0;
    initial_row = 8'd190; initial_col = 9'd270;
    tr_box[0] = 5; tr_box[1] = 6; tr_box[2] = 10; tr_box[3] = 9;
    load_order(4, 4);
    repeat (2) tick();
    all_zero("reset");
    reset = 1'b0; trace_screen_on = 1'b1;
    samp(0, 0, 0, 3);

    // In-order trace of boxes 5,6,10,9
    samp(1, 227, 307, 2);
    chk("t1_step1", 32'(trace_step), 32'd1);
    samp(1, 227, 332, 2);
    samp(1, 252, 332, 2);
    chk("t1_not_done_yet", 32'(trace_done), 32'd0);
    samp(1, 252, 307, 2);
    chk("t1_traced", 32'(p1_traced), 32'h0660);
    chk("t1_step",   32'(trace_step), 32'd4);
    chk("t1_done",   32'(trace_done), 32'd1);
    samp(0, 252, 307, 2);
    chk("t1_hold", 32'(p1_traced), 32'h0660);
    trace_screen_on = 1'b0;
    tick();
    chk("t6_scr_off_traced", 32'(p1_traced), 32'h0);
    chk("t6_scr_off_done",   32'(trace_done), 32'd0);
    trace_screen_on = 1'b1;
    samp(0, 0, 0, 2);

    // Out-of-order entry
    samp(1, 227, 307, 2);
    samp(1, 252, 332, 2);
    chk("t2_error",  32'(trace_error), 32'd1);
    chk("t2_traced", 32'(p1_traced), 32'h0400);
    samp(0, 252, 332, 2);
    chk("t2_lift_traced", 32'(p1_traced), 32'h0);
    chk("t2_lift_error",  32'(trace_error), 32'd0);

    // Leave and re-enter the same box
    samp(1, 227, 307, 2);
    samp(1, 100, 100, 2);
    samp(1, 227, 307, 2);
    chk("t3_step",   32'(trace_step), 32'd1);
    chk("t3_error",  32'(trace_error), 32'd0);
    chk("t3_traced", 32'(p1_traced), 32'h0400);
    samp(0, 227, 307, 2);

    // Pen lift mid-trace, then trace change mid-draw
    samp(1, 227, 307, 2);
    samp(1, 227, 332, 2);
    chk("t4_traced", 32'(p1_traced), 32'h0600);
    samp(0, 227, 332, 2);
    chk("t4_lift_traced", 32'(p1_traced), 32'h0);
    chk("t4_lift_step",   32'(trace_step), 32'd0);
    samp(1, 227, 307, 2);
    samp(1, 227, 332, 2);
    tr_box[0] = 6; tr_box[1] = 5;
    load_order(4, 4);
    tick();
    chk("t4_chg_traced", 32'(p1_traced), 32'h0);
    chk("t4_chg_step",   32'(trace_step), 32'd0);
    tr_box[0] = 5; tr_box[1] = 6;
    load_order(4, 4);
    tick();
    samp(0, 227, 332, 2);

    // Grid edges
    samp(1, 189, 269, 2);
    chk("t5_out_tl_step", 32'(trace_step), 32'd0);
    chk("t5_out_tl_err",  32'(trace_error), 32'd0);
    samp(1, 290, 370, 2);
    chk("t5_out_br_err",  32'(trace_error), 32'd0);
    samp(1, 190, 270, 2);
    chk("t5_box0_last", 32'(last_box), 32'd0);
    chk("t5_box0_err",  32'(trace_error), 32'd1);
    samp(0, 190, 270, 2);
    samp(1, 289, 369, 2);
    chk("t5_box15_last", 32'(last_box), 32'd15);
    samp(0, 289, 369, 2);

    // Reset while drawing
    samp(1, 227, 307, 2);
    samp(1, 227, 332, 2);
    chk("t6_pre_reset", 32'(p1_traced), 32'h0600);
    reset = 1'b1;
    tick();
    all_zero("t6_reset");
    reset = 1'b0;
    samp(0, 0, 0, 2);

    // Randomized traffic
    new_random_trace();
    for (int i = 0; i < 1500; i++) begin
      trace_screen_on = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 119) == 0) new_random_trace();
      if ($urandom_range(0, 19) == 0) pen_down = ~pen_down;
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 7);
        if (sel < 7) begin
          if (sel < 4 && m_step < tr_n) bx = tr_box[m_step];
          else if (sel < 5) bx = tr_box[$urandom_range(0, tr_n - 1)];
          else bx = $urandom_range(0, 15);
          cursor_row = 9'(int'(initial_row) + (bx / 4) * 25 + $urandom_range(0, 24));
          cursor_col = 10'(int'(initial_col) + (bx % 4) * 25 + $urandom_range(0, 24));
        end else begin
          cursor_row = 9'($urandom_range(0, 479));
          cursor_col = 10'($urandom_range(0, 639));
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
